// File: rtl/dmem_responder.sv
// Multi-cycle byte-addressed data memory for the RV32 load/store path, with programmable wait states.
// Optional DMEM_RESP_ERR_EN: flag misaligned or unsupported accesses through err instead of masking them.
module dmem_responder #(
   parameter int ADDR_W      = 8,
   parameter int WAIT_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        func3,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
   localparam bit         NO_WAIT  = (WAIT_CYCLES == 0);

   state_t            state;
   logic [3:0]        count;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [2:0]        lat_func3;
   logic [31:0]       lat_wdata;

   logic [7:0] mem [0:(2**ADDR_W)-1];

   logic              accept;
   logic              enter_resp;
   logic              use_inputs;
   logic              op_we;
   logic [ADDR_W-1:0] op_addr;
   logic [2:0]        op_func3;
   logic [31:0]       op_wdata;
   size_t             op_size;
   logic              op_uns;
   logic              op_err;
   logic [ADDR_W-1:0] eff_addr;
   logic [ADDR_W-1:0] addr1;
   logic [ADDR_W-1:0] addr2;
   logic [ADDR_W-1:0] addr3;
   logic [7:0]        rb0;
   logic [7:0]        rb1;
   logic [7:0]        rb2;
   logic [7:0]        rb3;
   logic [31:0]       load_val;
   logic              mem_wr;

   assign accept     = req && (state == IDLE || state == RESP);
   assign enter_resp = (state == WAIT && count == 4'd0) || (accept && NO_WAIT);
   assign busy       = (state == WAIT) || (state == RESP && !req);

   // With zero wait states the access happens on the accepting edge, so it must use the live inputs.
   assign use_inputs = (state != WAIT);
   assign op_we      = use_inputs ? we    : lat_we;
   assign op_addr    = use_inputs ? addr  : lat_addr;
   assign op_func3   = use_inputs ? func3 : lat_func3;
   assign op_wdata   = use_inputs ? wdata : lat_wdata;

   always_comb begin
      op_size  = SZ_W;
      op_uns   = 1'b0;
      op_err   = 1'b0;
      eff_addr = op_addr;
      case (op_func3)
         3'b000: op_size = SZ_B;
         3'b001: op_size = SZ_H;
         3'b010: op_size = SZ_W;
         3'b100: begin
            op_size = SZ_B;
            op_uns  = 1'b1;
         end
         3'b101: begin
            op_size = SZ_H;
            op_uns  = 1'b1;
         end
         default: begin
            op_size = SZ_W;
`ifdef DMEM_RESP_ERR_EN
            op_err  = 1'b1;
`endif
         end
      endcase
`ifdef DMEM_RESP_ERR_EN
      if (op_we && op_func3[2])
         op_err = 1'b1;
      if ((op_size == SZ_H && op_addr[0]) || (op_size == SZ_W && op_addr[1:0] != 2'b00))
         op_err = 1'b1;
`else
      if (op_size == SZ_H)
         eff_addr[0] = 1'b0;
      if (op_size == SZ_W)
         eff_addr[1:0] = 2'b00;
`endif
   end

   assign addr1 = eff_addr + ADDR_W'(1);
   assign addr2 = eff_addr + ADDR_W'(2);
   assign addr3 = eff_addr + ADDR_W'(3);
   assign rb0   = mem[eff_addr];
   assign rb1   = mem[addr1];
   assign rb2   = mem[addr2];
   assign rb3   = mem[addr3];

   always_comb begin
      load_val = {rb3, rb2, rb1, rb0};
      case (op_size)
         SZ_B:    load_val = {{24{~op_uns & rb0[7]}}, rb0};
         SZ_H:    load_val = {{16{~op_uns & rb1[7]}}, rb1, rb0};
         default: load_val = {rb3, rb2, rb1, rb0};
      endcase
   end

   // Gate on rst so a request presented during reset can never commit a store.
   assign mem_wr = enter_resp && rst && op_we && !op_err;

   always_ff @(posedge clk) begin
      if (mem_wr) begin
         mem[eff_addr] <= op_wdata[7:0];
         if (op_size != SZ_B)
            mem[addr1] <= op_wdata[15:8];
         if (op_size == SZ_W) begin
            mem[addr2] <= op_wdata[23:16];
            mem[addr3] <= op_wdata[31:24];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         count     <= 4'd0;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_func3 <= 3'b000;
         lat_wdata <= 32'd0;
         rdata     <= 32'd0;
         ready     <= 1'b0;
         err       <= 1'b0;
      end else begin
         ready <= 1'b0;
         err   <= 1'b0;
         case (state)
            WAIT: begin
               if (count == 4'd0)
                  state <= RESP;
               else
                  count <= count - 4'd1;
            end
            default: begin
               if (accept) begin
                  lat_we    <= we;
                  lat_addr  <= addr;
                  lat_func3 <= func3;
                  lat_wdata <= wdata;
                  count     <= CNT_LOAD;
                  state     <= NO_WAIT ? RESP : WAIT;
               end else begin
                  state <= IDLE;
               end
            end
         endcase
         if (enter_resp) begin
            ready <= 1'b1;
            err   <= op_err;
            if (op_err)
               rdata <= 32'd0;
            else if (!op_we)
               rdata <= load_val;
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance for data/latency/reset and a
// WAIT_CYCLES=0 instance for back-to-back throughput.
module tb_dmem_responder;

   logic        clk;
   int          checks;
   int          errors;

   logic        a_rst, a_req, a_we, a_ready, a_busy, a_err;
   logic [7:0]  a_addr;
   logic [2:0]  a_func3;
   logic [31:0] a_wdata, a_rdata;

   logic        b_rst, b_req, b_we, b_ready, b_busy, b_err;
   logic [7:0]  b_addr;
   logic [2:0]  b_func3;
   logic [31:0] b_wdata, b_rdata;

   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut_a (
      .clk(clk), .rst(a_rst), .req(a_req), .we(a_we), .addr(a_addr), .func3(a_func3),
      .wdata(a_wdata), .rdata(a_rdata), .ready(a_ready), .busy(a_busy), .err(a_err)
   );

   dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(0)) dut_b (
      .clk(clk), .rst(b_rst), .req(b_req), .we(b_we), .addr(b_addr), .func3(b_func3),
      .wdata(b_wdata), .rdata(b_rdata), .ready(b_ready), .busy(b_busy), .err(b_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Holds req until ready is seen (bounded), then drops it before the next edge.
   task automatic apply_stimulus(input logic st, input logic [7:0] ad, input logic [2:0] f3,
                                 input logic [31:0] wd, output logic [31:0] rd,
                                 output logic er, output int lat, output logic busy1);
      int i;
      @(negedge clk);
      a_req = 1'b1; a_we = st; a_addr = ad; a_func3 = f3; a_wdata = wd;
      lat = 0; rd = 32'd0; er = 1'b0; busy1 = 1'b0; i = 0;
      while (lat == 0 && i < 20) begin
         i++;
         @(posedge clk); #1;
         if (i == 1) busy1 = a_busy;
         if (a_ready) begin
            lat = i; rd = a_rdata; er = a_err;
         end
      end
      a_req = 1'b0;
   endtask

   task automatic run_access(input string tag, input logic st, input logic [7:0] ad,
                             input logic [2:0] f3, input logic [31:0] wd,
                             input logic [31:0] exp_rd, input logic exp_err);
      logic [31:0] rd;
      logic        er;
      int          lat;
      logic        busy1;
      apply_stimulus(st, ad, f3, wd, rd, er, lat, busy1);
      check_output($sformatf("%s.latency", tag), 32'(lat), 32'd3);
      check_output($sformatf("%s.busy_wait", tag), {31'd0, busy1}, 32'd1);
      check_output($sformatf("%s.rdata", tag), rd, exp_rd);
      check_output($sformatf("%s.err", tag), {31'd0, er}, {31'd0, exp_err});
   endtask

   initial begin
      logic [7:0]  b_addrs [4];
      logic [2:0]  b_f3s   [4];
      logic [31:0] b_exps  [4];
      logic        seen;

      checks = 0; errors = 0;
      a_rst = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = 8'd0; a_func3 = 3'd0; a_wdata = 32'd0;
      b_rst = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = 8'd0; b_func3 = 3'd0; b_wdata = 32'd0;
      $display("[TB] reset");
      repeat (2) @(posedge clk);
      #1;
      check_output("rst.ready", {31'd0, a_ready}, 32'd0);
      check_output("rst.busy", {31'd0, a_busy}, 32'd0);
      check_output("rst.err", {31'd0, a_err}, 32'd0);
      check_output("rst.rdata", a_rdata, 32'd0);
      @(negedge clk);
      a_rst = 1'b1; b_rst = 1'b1;

      $display("[TB] word/byte/halfword accesses, WAIT_CYCLES=2");
      run_access("sw10",  1'b1, 8'h10, 3'b010, 32'hDEADBEEF, 32'h00000000, 1'b0);
      run_access("lw10",  1'b0, 8'h10, 3'b010, 32'h0,       32'hDEADBEEF, 1'b0);
      run_access("lb13",  1'b0, 8'h13, 3'b000, 32'h0,       32'hFFFFFFDE, 1'b0);
      run_access("lbu13", 1'b0, 8'h13, 3'b100, 32'h0,       32'h000000DE, 1'b0);
      run_access("lh12",  1'b0, 8'h12, 3'b001, 32'h0,       32'hFFFFDEAD, 1'b0);
      run_access("lhu10", 1'b0, 8'h10, 3'b101, 32'h0,       32'h0000BEEF, 1'b0);
      run_access("sb11",  1'b1, 8'h11, 3'b000, 32'h00000055, 32'h0000BEEF, 1'b0);
      run_access("lw10b", 1'b0, 8'h10, 3'b010, 32'h0,       32'hDEAD55EF, 1'b0);
      run_access("sw20",  1'b1, 8'h20, 3'b010, 32'hCAFEF00D, 32'hDEAD55EF, 1'b0);
      run_access("lw20",  1'b0, 8'h20, 3'b010, 32'h0,       32'hCAFEF00D, 1'b0);

      $display("[TB] reset during WAIT of a store");
      @(negedge clk);
      a_req = 1'b1; a_we = 1'b1; a_addr = 8'h20; a_func3 = 3'b010; a_wdata = 32'h12345678;
      @(posedge clk); #1;
      check_output("abort.busy_before", {31'd0, a_busy}, 32'd1);
      a_rst = 1'b0; a_req = 1'b0;
      #1;
      check_output("abort.busy_in_rst", {31'd0, a_busy}, 32'd0);
      check_output("abort.rdata_in_rst", a_rdata, 32'd0);
      seen = 1'b0;
      repeat (4) begin
         @(posedge clk); #1;
         if (a_ready) seen = 1'b1;
      end
      check_output("abort.no_ready", {31'd0, seen}, 32'd0);
      @(negedge clk);
      a_rst = 1'b1;
      run_access("lw20_after_rst", 1'b0, 8'h20, 3'b010, 32'h0, 32'hCAFEF00D, 1'b0);

`ifdef DMEM_RESP_ERR_EN
      $display("[TB] error responses enabled");
      run_access("lw22_err",  1'b0, 8'h22, 3'b010, 32'h0,       32'h00000000, 1'b1);
      run_access("sw21_err",  1'b1, 8'h21, 3'b010, 32'hFFFFFFFF, 32'h00000000, 1'b1);
      run_access("lw20_same", 1'b0, 8'h20, 3'b010, 32'h0,       32'hCAFEF00D, 1'b0);
      run_access("sbu_err",   1'b1, 8'h20, 3'b100, 32'h00000011, 32'h00000000, 1'b1);
      run_access("lw20_same2",1'b0, 8'h20, 3'b010, 32'h0,       32'hCAFEF00D, 1'b0);
`else
      $display("[TB] alignment masking");
      run_access("lw22_mask", 1'b0, 8'h22, 3'b010, 32'h0,       32'hCAFEF00D, 1'b0);
      run_access("sh23_mask", 1'b1, 8'h23, 3'b001, 32'hAAAA1234, 32'hCAFEF00D, 1'b0);
      run_access("lw20_sh",   1'b0, 8'h20, 3'b010, 32'h0,       32'h1234F00D, 1'b0);
      run_access("l011_as_w", 1'b0, 8'h21, 3'b011, 32'h0,       32'h1234F00D, 1'b0);
      run_access("sbu_as_sb", 1'b1, 8'h20, 3'b100, 32'h00000077, 32'h1234F00D, 1'b0);
      run_access("lw20_sbu",  1'b0, 8'h20, 3'b010, 32'h0,       32'h1234F077, 1'b0);
`endif

      $display("[TB] back-to-back, WAIT_CYCLES=0");
      b_addrs = '{8'h00, 8'h00, 8'h03, 8'h02};
      b_f3s   = '{3'b010, 3'b000, 3'b100, 3'b001};
      b_exps  = '{32'h8822A3F4, 32'hFFFFFFF4, 32'h00000088, 32'hFFFF8822};
      @(negedge clk);
      b_req = 1'b1; b_we = 1'b1; b_addr = 8'h00; b_func3 = 3'b010; b_wdata = 32'h8822A3F4;
      @(posedge clk); #1;
      check_output("b2b.store_ready", {31'd0, b_ready}, 32'd1);
      check_output("b2b.store_busy", {31'd0, b_busy}, 32'd0);
      for (int k = 0; k < 4; k++) begin
         b_we = 1'b0; b_addr = b_addrs[k]; b_func3 = b_f3s[k]; b_wdata = 32'd0;
         @(posedge clk); #1;
         check_output($sformatf("b2b.ready%0d", k), {31'd0, b_ready}, 32'd1);
         check_output($sformatf("b2b.busy%0d", k), {31'd0, b_busy}, 32'd0);
         check_output($sformatf("b2b.rdata%0d", k), b_rdata, b_exps[k]);
      end
      b_req = 1'b0;
      @(posedge clk); #1;
      check_output("b2b.idle_ready", {31'd0, b_ready}, 32'd0);
      check_output("b2b.idle_busy", {31'd0, b_busy}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
